// File: rtl/tb_run_sequencer.sv
// rtl/tb_run_sequencer.sv - measurement-run sequencer for the arithmetic testbench
// Walks RESET -> RUN -> SETTLE -> SNAP, drives tb reset/enable/freeze, snapshots counters.
module tb_run_sequencer #(
  parameter int CNT_W         = 32,
  parameter int RST_CYCLES    = 4,
  parameter int SETTLE_CYCLES = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_start,
  input  logic             i_abort,
  input  logic [CNT_W-1:0] i_run_len,
  input  logic [CNT_W-1:0] i_data_ctr,
  input  logic [CNT_W-1:0] i_event_ctr,
  output logic             o_tb_reset,
  output logic             o_tb_enable,
  output logic             o_tb_freeze,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_aborted,
  output logic [2:0]       o_state,
  output logic [CNT_W-1:0] o_elapsed,
  output logic [CNT_W-1:0] o_snap_data,
  output logic [CNT_W-1:0] o_snap_event
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RESET  = 3'd1,
    S_RUN    = 3'd2,
    S_SETTLE = 3'd3,
    S_SNAP   = 3'd4
  } state_t;

  localparam int PH_MAX = (RST_CYCLES > SETTLE_CYCLES) ? RST_CYCLES : SETTLE_CYCLES;
  localparam int PH_W   = $clog2(PH_MAX + 1);
  localparam logic [PH_W-1:0] RST_LAST = PH_W'(RST_CYCLES - 1);
  localparam logic [PH_W-1:0] SET_LAST = PH_W'(SETTLE_CYCLES - 1);

  state_t           r_state;
  logic [PH_W-1:0]  r_phase;
  logic [CNT_W-1:0] r_run_len;
  logic [CNT_W-1:0] r_elapsed;
  logic [CNT_W-1:0] r_snap_data;
  logic [CNT_W-1:0] r_snap_event;
  logic             r_tb_reset;
  logic             r_tb_enable;
  logic             r_tb_freeze;
  logic             r_busy;
  logic             r_done;
  logic             r_aborted;

  state_t           w_state_nxt;
  logic             w_start_ok;
  logic             w_run_last;
  logic [PH_W-1:0]  w_phase_nxt;
  logic [CNT_W-1:0] w_run_len_nxt;
  logic [CNT_W-1:0] w_elapsed_nxt;
  logic [CNT_W-1:0] w_snap_data_nxt;
  logic [CNT_W-1:0] w_snap_event_nxt;
  logic             w_tb_reset_nxt;
  logic             w_tb_enable_nxt;
  logic             w_tb_freeze_nxt;
  logic             w_busy_nxt;
  logic             w_done_nxt;
  logic             w_aborted_nxt;

  assign w_start_ok = i_start && (r_state == S_IDLE);
  // RUN is never entered with run_len==0, so run_len-1 cannot underflow here
  assign w_run_last = (r_elapsed == (r_run_len - CNT_W'(1)));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_phase      <= '0;
      r_run_len    <= '0;
      r_elapsed    <= '0;
      r_snap_data  <= '0;
      r_snap_event <= '0;
      r_tb_reset   <= 1'b1;
      r_tb_enable  <= 1'b0;
      r_tb_freeze  <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_aborted    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_phase      <= w_phase_nxt;
      r_run_len    <= w_run_len_nxt;
      r_elapsed    <= w_elapsed_nxt;
      r_snap_data  <= w_snap_data_nxt;
      r_snap_event <= w_snap_event_nxt;
      r_tb_reset   <= w_tb_reset_nxt;
      r_tb_enable  <= w_tb_enable_nxt;
      r_tb_freeze  <= w_tb_freeze_nxt;
      r_busy       <= w_busy_nxt;
      r_done       <= w_done_nxt;
      r_aborted    <= w_aborted_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_start) w_state_nxt = S_RESET;
      end
      S_RESET: begin
        if (i_abort) begin
          w_state_nxt = S_IDLE;
        end else if (r_phase == RST_LAST) begin
          w_state_nxt = (r_run_len == '0) ? S_SETTLE : S_RUN;
        end
      end
      S_RUN: begin
        if (i_abort || w_run_last) w_state_nxt = S_SETTLE;
      end
      S_SETTLE: begin
        if (r_phase == SET_LAST) w_state_nxt = S_SNAP;
      end
      S_SNAP: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Registered outputs are computed from the state being entered so they align with o_state.
  always_comb begin
    w_phase_nxt      = r_phase;
    w_run_len_nxt    = r_run_len;
    w_elapsed_nxt    = r_elapsed;
    w_snap_data_nxt  = r_snap_data;
    w_snap_event_nxt = r_snap_event;
    w_done_nxt       = r_done;
    w_aborted_nxt    = r_aborted;
    w_tb_reset_nxt   = r_tb_reset;
    w_tb_enable_nxt  = 1'b0;
    w_tb_freeze_nxt  = r_tb_freeze;
    w_busy_nxt       = (w_state_nxt != S_IDLE);

    if (w_state_nxt != r_state) begin
      w_phase_nxt = '0;
    end else if (r_state == S_RESET || r_state == S_SETTLE) begin
      w_phase_nxt = r_phase + PH_W'(1);
    end

    if (w_start_ok) begin
      w_run_len_nxt = i_run_len;
      w_elapsed_nxt = '0;
      w_done_nxt    = 1'b0;
      w_aborted_nxt = 1'b0;
    end

    if (r_state == S_RUN) w_elapsed_nxt = r_elapsed + CNT_W'(1);

    if ((r_state == S_RESET || r_state == S_RUN) && i_abort) w_aborted_nxt = 1'b1;
    if (r_state == S_RESET && i_abort) w_done_nxt = 1'b1;

    if (r_state == S_SNAP) begin
      w_snap_data_nxt  = i_data_ctr;
      w_snap_event_nxt = i_event_ctr;
      w_done_nxt       = 1'b1;
    end

    case (w_state_nxt)
      S_RESET: begin
        w_tb_reset_nxt  = 1'b1;
        w_tb_freeze_nxt = 1'b0;
      end
      S_RUN: begin
        w_tb_reset_nxt  = 1'b0;
        w_tb_enable_nxt = 1'b1;
        w_tb_freeze_nxt = 1'b0;
      end
      S_SETTLE, S_SNAP: begin
        w_tb_reset_nxt  = 1'b0;
        w_tb_freeze_nxt = 1'b1;
      end
      default: begin
        // Returning to IDLE leaves the testbench out of reset and frozen for readout.
        if (r_state != S_IDLE) begin
          w_tb_reset_nxt  = 1'b0;
          w_tb_freeze_nxt = 1'b1;
        end
      end
    endcase
  end

  assign o_state      = r_state;
  assign o_tb_reset   = r_tb_reset;
  assign o_tb_enable  = r_tb_enable;
  assign o_tb_freeze  = r_tb_freeze;
  assign o_busy       = r_busy;
  assign o_done       = r_done;
  assign o_aborted    = r_aborted;
  assign o_elapsed    = r_elapsed;
  assign o_snap_data  = r_snap_data;
  assign o_snap_event = r_snap_event;

endmodule
